sync_sp_ram: RTL and testbench

Parametrised single-clock, single-port RAM with a valid/ready request port, per-byte write enables, an optional output register and a selectable read-during-write mode. After every reset it runs a hardware clear sequence that zeroes the whole array. It is the next-generation storage block of the design. It replaces the fixed 16x8 dual-clock bidirectional-bus RAM with a single-clock, split-data-bus part that can be dropped in wherever a local buffer or register file is needed.

---
 rtl/sync_sp_ram.sv | 182 ++++++++++++++++++
 tb/tb_sync_sp_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_sp_ram
// Purpose  : Single-clock single-port RAM, valid/ready request, byte enables,
//            optional output register, hardware clear after every reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_sp_ram #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int BYTE_W   = 8,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W/BYTE_W-1:0]   req_be,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       init_busy
);

  localparam int                c_depth    = 2 ** ADDR_W;
  localparam int                c_nbe      = DATA_W / BYTE_W;
  localparam logic [ADDR_W-1:0] c_addr_max = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   mem_q [c_depth];

  logic                w_accept;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [c_nbe-1:0]    w_mem_be;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_old_word;
  logic [DATA_W-1:0]   w_merged_word;

  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                valid1_q;
  logic                w_valid_pipe;

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    req_ready  = 1'b0;
    init_busy  = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + c_addr_one;
        if (clr_addr_q == c_addr_max) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        req_ready = 1'b1;
        init_busy = 1'b0;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign w_accept = req_valid && req_ready;

  // ------------------------------------------------------------------------
  // Single shared memory port: the clear engine owns it while in CLEAR
  // ------------------------------------------------------------------------
  always_comb begin
    if (state_q == ST_CLEAR) begin
      w_mem_we    = rst;
      w_mem_addr  = clr_addr_q;
      w_mem_be    = '1;
      w_mem_wdata = '0;
    end else begin
      w_mem_we    = w_accept && req_we;
      w_mem_addr  = req_addr;
      w_mem_be    = req_be;
      w_mem_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < c_nbe; i++) begin
        if (w_mem_be[i]) begin
          mem_q[w_mem_addr][i*BYTE_W +: BYTE_W] <= w_mem_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign w_old_word = mem_q[w_mem_addr];

  generate
    for (genvar g = 0; g < c_nbe; g++) begin : g_merge
      assign w_merged_word[g*BYTE_W +: BYTE_W] = req_be[g] ? req_wdata[g*BYTE_W +: BYTE_W]
                                                           : w_old_word[g*BYTE_W +: BYTE_W];
    end
  endgenerate

  // ------------------------------------------------------------------------
  // Read stage: writes also steer the data register according to RDW_MODE
  // ------------------------------------------------------------------------
  always_comb begin
    rdata1_d = rdata1_q;
    if (w_accept) begin
      if (!req_we) begin
        rdata1_d = w_old_word;
      end else begin
        case (RDW_MODE)
          1:       rdata1_d = w_merged_word;
          2:       rdata1_d = rdata1_q;
          default: rdata1_d = w_old_word;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata1_q <= '0;
      valid1_q <= 1'b0;
    end else begin
      rdata1_q <= rdata1_d;
      valid1_q <= w_accept && !req_we;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] rdata2_q;
      logic              valid2_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          rdata2_q <= '0;
          valid2_q <= 1'b0;
        end else begin
          rdata2_q <= rdata1_q;
          valid2_q <= valid1_q;
        end
      end

      assign rsp_rdata    = rdata2_q;
      assign w_valid_pipe = valid2_q;
    end else begin : g_no_out_reg
      assign rsp_rdata    = rdata1_q;
      assign w_valid_pipe = valid1_q;
    end
  endgenerate

  // A reset on the edge where a response would be consumed cancels it.
  assign rsp_valid = w_valid_pipe && rst;

endmodule
`default_nettype wire

// File: tb/tb_sync_sp_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_sp_ram
// Purpose  : Directed table-driven bench for sync_sp_ram (four configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_sp_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;

  logic [3:0]  rdy;
  logic [3:0]  vld;
  logic [3:0]  bsy;
  logic [15:0] rd [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: latency 1 / READ_FIRST, 1: latency 2 / READ_FIRST,
  // 2: latency 1 / WRITE_FIRST, 3: latency 1 / NO_CHANGE
  sync_sp_ram #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .init_busy(bsy[0]));
  sync_sp_ram #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .OUT_REG(1), .RDW_MODE(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .init_busy(bsy[1]));
  sync_sp_ram #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(1)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_rdata(rd[2]), .init_busy(bsy[2]));
  sync_sp_ram #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .OUT_REG(0), .RDW_MODE(2)) u_d (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[3]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(vld[3]), .rsp_rdata(rd[3]), .init_busy(bsy[3]));

  typedef struct {
    logic        v;
    logic        we;
    logic [2:0]  addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        ev;
    logic [15:0] erd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] a,
                       input logic [1:0] be, input logic [15:0] wd);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
  endtask

  // Expected values below are for the latency-1 READ_FIRST instance.
  function automatic void v_rd(input logic [2:0] a, input logic [15:0] exp);
    vq.push_back('{1'b1, 1'b0, a, 2'b00, 16'h0000, 1'b1, exp});
  endfunction

  function automatic void v_wr(input logic [2:0] a, input logic [1:0] be,
                               input logic [15:0] d, input logic [15:0] old_word);
    vq.push_back('{1'b1, 1'b1, a, be, d, 1'b0, old_word});
  endfunction

  function automatic void v_idle(input logic [15:0] hold);
    vq.push_back('{1'b0, 1'b0, 3'd0, 2'b00, 16'h0000, 1'b0, hold});
  endfunction

  // Counts cycles with init_busy high; inputs at entry are whatever the caller drives.
  task automatic clear_wait(input string tag);
    int cnt = 0;
    while (bsy[0] && cnt < 50) begin
      @(negedge clk);
      cnt++;
      chk({tag, " no rsp during clear"}, vld[0], 1'b0);
    end
    chk({tag, " busy cycles"}, cnt, 8);
    chk({tag, " ready all"}, rdy, 4'hF);
    chk({tag, " busy all low"}, bsy, 4'h0);
  endtask

  initial begin
    logic        pv;
    logic [15:0] prd;

    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
    repeat (3) @(negedge clk);

    chk("reset ready", rdy, 4'h0);
    chk("reset busy", bsy, 4'hF);
    chk("reset valid", vld, 4'h0);
    chk("reset rdata A", rd[0], 16'h0000);
    chk("reset rdata B", rd[1], 16'h0000);

    rst = 1'b1;
    clear_wait("clear1");

    for (int a = 0; a < 8; a++) v_rd(3'(a), 16'h0000);
    v_wr(3'd7, 2'b11, 16'd200, 16'd0);
    v_wr(3'd6, 2'b11, 16'd50,  16'd0);
    v_wr(3'd4, 2'b11, 16'd110, 16'd0);
    v_wr(3'd1, 2'b11, 16'd40,  16'd0);
    v_wr(3'd2, 2'b11, 16'd60,  16'd0);
    v_wr(3'd7, 2'b11, 16'd10,  16'd200);
    v_wr(3'd3, 2'b11, 16'd150, 16'd0);
    v_rd(3'd7, 16'd10);
    v_rd(3'd4, 16'd110);
    v_rd(3'd4, 16'd110);
    v_rd(3'd2, 16'd60);
    v_rd(3'd7, 16'd10);
    v_rd(3'd3, 16'd150);
    v_idle(16'd150);
    v_wr(3'd5, 2'b11, 16'h1234, 16'h0000);
    v_wr(3'd5, 2'b01, 16'hABCD, 16'h1234);
    v_wr(3'd5, 2'b00, 16'hFFFF, 16'h12CD);
    v_rd(3'd5, 16'h12CD);
    v_rd(3'd2, 16'd60);
    v_wr(3'd2, 2'b11, 16'h00FF, 16'd60);
    v_rd(3'd2, 16'h00FF);
    v_idle(16'h00FF);

    pv  = 1'b0;
    prd = 16'h0000;
    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].we, vq[i].addr, vq[i].be, vq[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d A valid", i), vld[0], vq[i].ev);
      chk($sformatf("vec%0d A rdata", i), rd[0], vq[i].erd);
      chk($sformatf("vec%0d B valid", i), vld[1], pv);
      chk($sformatf("vec%0d B rdata", i), rd[1], prd);
      chk($sformatf("vec%0d C valid", i), vld[2], vq[i].ev);
      chk($sformatf("vec%0d D valid", i), vld[3], vq[i].ev);
      pv  = vq[i].ev;
      prd = vq[i].erd;
    end

    // Read-during-write behaviour on addr 7 (=10) after reading addr 3 (=150)
    drive(1'b1, 1'b0, 3'd3, 2'b00, 16'h0000);
    @(negedge clk);
    chk("rdw pre A", rd[0], 16'd150);
    chk("rdw pre C", rd[2], 16'd150);
    chk("rdw pre D", rd[3], 16'd150);
    drive(1'b1, 1'b1, 3'd7, 2'b11, 16'hBEEF);
    @(negedge clk);
    chk("rdw A valid", vld[0], 1'b0);
    chk("rdw C valid", vld[2], 1'b0);
    chk("rdw D valid", vld[3], 1'b0);
    chk("rdw read_first", rd[0], 16'd10);
    chk("rdw write_first", rd[2], 16'hBEEF);
    chk("rdw no_change", rd[3], 16'd150);
    chk("rdw B prior read valid", vld[1], 1'b1);
    chk("rdw B prior read rdata", rd[1], 16'd150);
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
    @(negedge clk);
    chk("rdw B read_first", rd[1], 16'd10);
    chk("rdw B valid", vld[1], 1'b0);
    chk("rdw hold A", rd[0], 16'd10);
    chk("rdw hold C", rd[2], 16'hBEEF);
    chk("rdw hold D", rd[3], 16'd150);

    // Reset on the edge right after a read is accepted
    drive(1'b1, 1'b0, 3'd3, 2'b00, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
    #1;
    chk("midrst A valid dropped", vld[0], 1'b0);
    @(negedge clk);
    chk("midrst valid all", vld, 4'h0);
    chk("midrst busy all", bsy, 4'hF);
    chk("midrst ready all", rdy, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 3'd3, 2'b00, 16'h0000);
    clear_wait("clear2");
    @(negedge clk);
    chk("post clear A valid", vld[0], 1'b1);
    chk("post clear A rdata", rd[0], 16'h0000);
    drive(1'b0, 1'b0, 3'd0, 2'b00, 16'h0000);
    @(negedge clk);
    chk("post clear A idle", vld[0], 1'b0);
    chk("post clear B valid", vld[1], 1'b1);
    chk("post clear B rdata", rd[1], 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
